// File: rtl/seq_loop_checker.sv
// ============================================================================
// seq_loop_checker
//
// Purpose
//   Watches the state sequence of an FSM and recognises one loop structure in
//   it. It reports when the loop is active, pulses once per completed
//   iteration and once per loop exit, and counts iterations and loop passes.
//   It flags protocol errors, and the first error code is kept.
//
// Parameters
//   FSM_WIDTH   - width of every state-encoding input
//   CNT_WIDTH   - width of iter_cnt / last_iter_cnt / loop_cnt
//   STALL_LIMIT - (SEQ_LOOP_CHECKER_STALL_EN only) stall threshold in cycles
//
// Optional feature
//   SEQ_LOOP_CHECKER_STALL_EN : when defined, adds a stall watchdog. The
//   watchdog raises err_code=3 after STALL_LIMIT consecutive LOOP cycles in
//   which the state does not change and no iteration ends.
//
// Ports
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   cur_state              : observed FSM state
//   pre_*                  : loop-entry predecessor state
//   post_*                 : up to five exit target states, individually valid
//   quit_*, loop_quit_state: quit transition (source -> target)
//   iter_start_state       : first state of an iteration
//   iter_end_*             : last state of an iteration
//   one_state_loop/block   : single-state iteration / single-state loop body
//   finish                 : end of observation, freezes the checker
//   in_loop, iter_pulse, exit_pulse, iter_cnt, last_iter_cnt, loop_cnt,
//   done, err, err_code    : registered status outputs
// ============================================================================
module seq_loop_checker #(
    parameter int FSM_WIDTH = 2,
    parameter int CNT_WIDTH = 16
`ifdef SEQ_LOOP_CHECKER_STALL_EN
    ,
    parameter int STALL_LIMIT = 1024
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [FSM_WIDTH-1:0] cur_state,
    input  logic                 pre_states_valid,
    input  logic [FSM_WIDTH-1:0] pre_loop_state0,
    input  logic [4:0]           post_states_valid,
    input  logic [FSM_WIDTH-1:0] post_loop_state0,
    input  logic [FSM_WIDTH-1:0] post_loop_state1,
    input  logic [FSM_WIDTH-1:0] post_loop_state2,
    input  logic [FSM_WIDTH-1:0] post_loop_state3,
    input  logic [FSM_WIDTH-1:0] post_loop_state4,
    input  logic                 quit_states_valid,
    input  logic [FSM_WIDTH-1:0] quit_loop_state0,
    input  logic [FSM_WIDTH-1:0] loop_quit_state,
    input  logic [FSM_WIDTH-1:0] iter_start_state,
    input  logic                 iter_end_states_valid,
    input  logic [FSM_WIDTH-1:0] iter_end_state0,
    input  logic                 one_state_loop,
    input  logic                 one_state_block,
    input  logic                 finish,
    output logic                 in_loop,
    output logic                 iter_pulse,
    output logic                 exit_pulse,
    output logic [CNT_WIDTH-1:0] iter_cnt,
    output logic [CNT_WIDTH-1:0] last_iter_cnt,
    output logic [CNT_WIDTH-1:0] loop_cnt,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOOP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [FSM_WIDTH-1:0]   r_prev_state;
    logic                   r_in_loop;
    logic                   r_iter_pulse;
    logic                   r_exit_pulse;
    logic [CNT_WIDTH-1:0]   r_iter_cnt;
    logic [CNT_WIDTH-1:0]   r_last_iter_cnt;
    logic [CNT_WIDTH-1:0]   r_loop_cnt;
    logic                   r_done;
    logic                   r_err;
    logic [1:0]             r_err_code;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Event detection on the current sample
    // ------------------------------------------------------------------
    logic [FSM_WIDTH-1:0] w_post_state [5];
    logic [4:0]           w_post_match;
    logic                 w_iter_end;
    logic                 w_quit_hit;
    logic                 w_exit;
    logic                 w_reentry;
    logic                 w_at_start;
    logic [CNT_WIDTH-1:0] w_iter_cnt_upd;
    logic                 w_stall_hit;

    assign w_post_state[0] = post_loop_state0;
    assign w_post_state[1] = post_loop_state1;
    assign w_post_state[2] = post_loop_state2;
    assign w_post_state[3] = post_loop_state3;
    assign w_post_state[4] = post_loop_state4;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_post
            assign w_post_match[gi] = post_states_valid[gi] && (cur_state == w_post_state[gi]);
        end
    endgenerate

    assign w_at_start = (cur_state == iter_start_state);
    assign w_iter_end = (iter_end_states_valid && (cur_state == iter_end_state0))
                     || (one_state_loop && w_at_start);
    // Quit is a transition, so it needs the previous sample as well.
    assign w_quit_hit = quit_states_valid && (r_prev_state == quit_loop_state0)
                     && (cur_state == loop_quit_state);
    assign w_exit     = (|w_post_match) || w_quit_hit;
    assign w_reentry  = pre_states_valid && (cur_state == pre_loop_state0);

    // Iteration count including an iteration that ends this cycle, so an
    // exit coinciding with an iteration end reports the full count.
    assign w_iter_cnt_upd = w_iter_end ? sat_inc(r_iter_cnt) : r_iter_cnt;

`ifdef SEQ_LOOP_CHECKER_STALL_EN
    // ------------------------------------------------------------------
    // Stall watchdog: length of the current run of identical LOOP samples
    // with no iteration end. A state change restarts the run at 1.
    // ------------------------------------------------------------------
    localparam int STALL_CW = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_CW-1:0] STALL_MAX = STALL_CW'(STALL_LIMIT);

    logic [STALL_CW-1:0] r_stall_cnt;
    logic [STALL_CW-1:0] w_stall_next;
    logic                w_stall_run;

    assign w_stall_run  = (r_state == ST_LOOP) && !finish && !w_iter_end;
    assign w_stall_next = !w_stall_run                  ? '0 :
                          (cur_state != r_prev_state)   ? {{(STALL_CW-1){1'b0}}, 1'b1} :
                          (r_stall_cnt == STALL_MAX)    ? r_stall_cnt :
                                                          r_stall_cnt + {{(STALL_CW-1){1'b0}}, 1'b1};
    assign w_stall_hit  = w_stall_run && (w_stall_next >= STALL_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= w_stall_next;
        end
    end
`else
    assign w_stall_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Main FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_prev_state    <= '0;
            r_in_loop       <= 1'b0;
            r_iter_pulse    <= 1'b0;
            r_exit_pulse    <= 1'b0;
            r_iter_cnt      <= '0;
            r_last_iter_cnt <= '0;
            r_loop_cnt      <= '0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_err_code      <= 2'd0;
        end else begin
            r_prev_state <= cur_state;
            r_iter_pulse <= 1'b0;
            r_exit_pulse <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (finish) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_reentry) begin
                        r_state <= ST_ARMED;
                    end else if (one_state_block && w_at_start) begin
                        // Single-state loop body: the entry sample is already
                        // inside the body, so with one_state_loop it is also
                        // the first completed iteration.
                        r_state      <= ST_LOOP;
                        r_in_loop    <= 1'b1;
                        r_iter_cnt   <= one_state_loop ? CNT_ONE : '0;
                        r_iter_pulse <= one_state_loop;
                    end
                end

                ST_ARMED: begin
                    if (finish) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_at_start) begin
                        r_state    <= ST_LOOP;
                        r_in_loop  <= 1'b1;
                        r_iter_cnt <= '0;
                    end else if (cur_state != pre_loop_state0) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_LOOP: begin
                    if (finish) begin
                        r_state   <= ST_DONE;
                        r_in_loop <= 1'b0;
                        r_done    <= 1'b1;
                        if (!r_err) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                        end
                    end else begin
                        if (w_iter_end) begin
                            r_iter_cnt   <= w_iter_cnt_upd;
                            r_iter_pulse <= 1'b1;
                        end
                        if (w_exit) begin
                            r_state         <= ST_IDLE;
                            r_in_loop       <= 1'b0;
                            r_exit_pulse    <= 1'b1;
                            r_last_iter_cnt <= w_iter_cnt_upd;
                            r_loop_cnt      <= sat_inc(r_loop_cnt);
                        end else if (w_reentry) begin
                            // Predecessor seen again without a recognised exit.
                            r_state   <= ST_ARMED;
                            r_in_loop <= 1'b0;
                            if (!r_err) begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'd1;
                            end
                        end
                        if (w_stall_hit && !w_exit && !w_reentry && !r_err) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd3;
                        end
                    end
                end

                default: begin
                    // ST_DONE: frozen until reset.
                end
            endcase
        end
    end

    assign in_loop       = r_in_loop;
    assign iter_pulse    = r_iter_pulse;
    assign exit_pulse    = r_exit_pulse;
    assign iter_cnt      = r_iter_cnt;
    assign last_iter_cnt = r_last_iter_cnt;
    assign loop_cnt      = r_loop_cnt;
    assign done          = r_done;
    assign err           = r_err;
    assign err_code      = r_err_code;

endmodule

// File: doc/seq_loop_checker.md
SEQ_LOOP_CHECKER -- requirements
Module: seq_loop_checker

Interface
REQ-001 The block SHALL have parameter FSM_WIDTH, default 2, giving the width of every state-encoding input.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of iter_cnt, last_iter_cnt and loop_cnt.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports: clock in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-004 The block SHALL have these state-description inputs:
- cur_state in FSM_WIDTH: observed FSM state.
- pre_states_valid in 1, pre_loop_state0 in FSM_WIDTH: loop-entry predecessor.
- post_states_valid in 5, post_loop_state0..4 in FSM_WIDTH each: exit targets, bit N qualifies post_loop_stateN.
- quit_states_valid in 1, quit_loop_state0 in FSM_WIDTH, loop_quit_state in FSM_WIDTH: quit source/target pair.
- iter_start_state in FSM_WIDTH; iter_end_states_valid in 1, iter_end_state0 in FSM_WIDTH.
- one_state_loop in 1, one_state_block in 1, finish in 1.
REQ-005 The block SHALL have these outputs:
- in_loop out 1.
- iter_pulse out 1: one-cycle pulse per completed iteration.
- exit_pulse out 1: one-cycle pulse per loop exit.
- iter_cnt, last_iter_cnt, loop_cnt out CNT_WIDTH each.
- done out 1.
- err out 1; err_code out 2.

Function
REQ-006 The FSM SHALL have the states IDLE, ARMED, LOOP and DONE; in_loop SHALL be 1 only in LOOP.
REQ-007 In IDLE, if pre_states_valid and cur_state==pre_loop_state0, the FSM SHALL go to ARMED; else if one_state_block and cur_state==iter_start_state, the FSM SHALL go to LOOP.
REQ-008 In ARMED, the FSM SHALL behave as follows:
- cur_state==iter_start_state: go to LOOP and clear iter_cnt.
- cur_state==pre_loop_state0: stay in ARMED.
- otherwise: go to IDLE.
REQ-009 In LOOP, an iteration end SHALL be detected by either of:
- iter_end_states_valid and cur_state==iter_end_state0;
- one_state_loop and cur_state==iter_start_state.
REQ-010 Each detected iteration end SHALL increment iter_cnt and assert iter_pulse on the next cycle.
REQ-011 iter_cnt and loop_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-012 In LOOP, a loop exit SHALL be detected by either of:
- cur_state==post_loop_stateN with post_states_valid[N] set, for any N;
- quit_states_valid and previous cur_state==quit_loop_state0 and cur_state==loop_quit_state.
REQ-013 On a loop exit, the block SHALL, on the next cycle:
- go to IDLE;
- pulse exit_pulse;
- copy iter_cnt into last_iter_cnt;
- increment loop_cnt.
REQ-014 If an iteration end and a loop exit occur in the same cycle, the iteration SHALL be counted first and last_iter_cnt SHALL include it.
REQ-015 In LOOP, cur_state==pre_loop_state0 with pre_states_valid set (re-entry without exit) SHALL set err with err_code=1 and SHALL move the FSM to ARMED.
REQ-016 finish=1 in any state SHALL move the FSM to DONE; done SHALL then be 1 and sticky until reset.
REQ-017 finish=1 while in LOOP SHALL set err with err_code=2.
REQ-018 In DONE, all inputs other than reset SHALL be ignored.
REQ-019 err SHALL be sticky; err_code SHALL hold the first error recorded; later errors SHALL NOT overwrite it.
REQ-020 Every output SHALL be registered, giving one-cycle latency from the sampled inputs.

Reset
REQ-021 While reset=1 at a clock edge, the FSM SHALL go to IDLE and every output SHALL be 0, including all counters, done, err and err_code.
REQ-022 Reset asserted mid-loop SHALL discard the loop without updating last_iter_cnt or loop_cnt.

Configuration
REQ-023 With macro SEQ_LOOP_CHECKER_STALL_EN defined, the block SHALL:
- add parameter STALL_LIMIT, default 1024;
- count consecutive LOOP cycles with cur_state unchanged and no iteration end;
- set err with err_code=3 when the count reaches STALL_LIMIT.
REQ-024 The stall count SHALL clear on any state change.
REQ-025 Without SEQ_LOOP_CHECKER_STALL_EN, no stall logic SHALL exist and err_code=3 SHALL never occur.

Verification
REQ-026 Entry and iterations, with pre_loop_state0=0, iter_start_state=1, iter_end_state0=2, post_loop_state0=3 and only post_states_valid[0] set: cur_state 0,1,2,1,2,1,2,3 -> three iter_pulses, last_iter_cnt=3, loop_cnt=1, one exit_pulse.
REQ-027 one_state_loop=1, one_state_block=1, iter_start_state=1: cur_state 1 held for 5 cycles, then 3 -> last_iter_cnt=5, with no ARMED visit.
REQ-028 finish=1 while in LOOP -> done=1, err=1, err_code=2; a subsequent entry sequence leaves loop_cnt unchanged.
REQ-029 Re-entry (pre_loop_state0 seen mid-LOOP), then finish while in LOOP -> err_code=1, not 2.
REQ-030 CNT_WIDTH=4 with 20 iterations -> iter_cnt holds at 15; reset mid-loop -> all outputs 0, loop_cnt=0.
REQ-031 With SEQ_LOOP_CHECKER_STALL_EN and STALL_LIMIT=8: cur_state held at 2 in LOOP for 8 cycles -> err_code=3; the same stimulus with the macro undefined -> err=0.
